// File: rtl/ra_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised 2-read/1-write register array.
package ra_pkg;

   localparam int unsigned SHARD_W    = 24;
   localparam int unsigned BANK_DEPTH = 64;
   localparam int unsigned ROW_W      = 6;

   function automatic int unsigned bank_idx(input int unsigned adr);
      return adr / BANK_DEPTH;
   endfunction

   function automatic bit width_legal(input int unsigned w);
      return (w >= 24) && (w <= 144) && ((w % SHARD_W) == 0);
   endfunction

   function automatic bit depth_legal(input int unsigned d);
      return (d >= 64) && (d <= 256) && ((d % BANK_DEPTH) == 0);
   endfunction

endpackage

// File: rtl/ra_bank_64_2r1w.sv
// One 64-row bank: a row write decoder qualified by the array strobe, plus WIDTH/24 storage shards
// with two gated combinational read ports.
module ra_bank_64_2r1w
   import ra_pkg::*;
#(
   parameter int unsigned WIDTH   = 72,
   parameter int unsigned GENMODE = 0
) (
   input  logic             clk,
   input  logic             strobe,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en_0,
   input  logic [ROW_W-1:0] rd_row_0,
   output logic [WIDTH-1:0] rd_dat_0,
   input  logic             rd_en_1,
   input  logic [ROW_W-1:0] rd_row_1,
   output logic [WIDTH-1:0] rd_dat_1
);

   localparam int unsigned NSHARD = WIDTH / SHARD_W;

   if (GENMODE > 1) begin : g_bad_genmode
      $error("ra_bank_64_2r1w: GENMODE must be 0 or 1");
   end

   logic [BANK_DEPTH-1:0] w_wr_dec;

   // One-hot row write select
   always_comb begin
      w_wr_dec = '0;
      if (wr_en && strobe) begin
         w_wr_dec[wr_row] = 1'b1;
      end
   end

   for (genvar s = 0; s < NSHARD; s++) begin : g_shard
      logic [SHARD_W-1:0] r_mem [BANK_DEPTH];

      always_ff @(posedge clk) begin
         for (int unsigned r = 0; r < BANK_DEPTH; r++) begin
            if (w_wr_dec[r]) begin
               r_mem[r] <= wr_dat[s*SHARD_W +: SHARD_W];
            end
         end
      end

      // Disabled ports read as zero so the top level can OR banks together
      assign rd_dat_0[s*SHARD_W +: SHARD_W] = rd_en_0 ? r_mem[rd_row_0] : '0;
      assign rd_dat_1[s*SHARD_W +: SHARD_W] = rd_en_1 ? r_mem[rd_row_1] : '0;
   end

endmodule

// File: rtl/ra_param_2r1w.sv
// Parameterised 2-read/1-write register array built from 64-row banks with input capture stage.
// Define RA_WR_BYPASS_EN to forward same-cycle write data to colliding reads.
module ra_param_2r1w
   import ra_pkg::*;
#(
   parameter  int unsigned WIDTH   = 72,
   parameter  int unsigned DEPTH   = 128,
   parameter  int unsigned LATCHRD = 1,
   parameter  int unsigned GENMODE = 0,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned NBANK   = DEPTH / BANK_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             rd_enb_0,
   input  logic [AW-1:0]    rd_adr_0,
   output logic [WIDTH-1:0] rd_dat_0,
   output logic             rd_val_0,
   input  logic             rd_enb_1,
   input  logic [AW-1:0]    rd_adr_1,
   output logic [WIDTH-1:0] rd_dat_1,
   output logic             rd_val_1,
   input  logic             wr_enb_0,
   input  logic [AW-1:0]    wr_adr_0,
   input  logic [WIDTH-1:0] wr_dat_0,
   output logic             adr_err
);

   if (!width_legal(WIDTH)) begin : g_bad_width
      $error("ra_param_2r1w: WIDTH must be a multiple of 24 in 24..144");
   end
   if (!depth_legal(DEPTH)) begin : g_bad_depth
      $error("ra_param_2r1w: DEPTH must be a multiple of 64 in 64..256");
   end
   if (LATCHRD > 1) begin : g_bad_latchrd
      $error("ra_param_2r1w: LATCHRD must be 0 or 1");
   end

   logic             r_strobe;
   logic             r_rd_enb_0, r_rd_enb_1, r_wr_enb_0;
   logic [AW-1:0]    r_rd_adr_0, r_rd_adr_1, r_wr_adr_0;
   logic [WIDTH-1:0] r_wr_dat_0;
   logic             r_adr_err;
   logic             w_err_in;

   assign w_err_in = (rd_enb_0 && (32'(rd_adr_0) >= DEPTH))
                  || (rd_enb_1 && (32'(rd_adr_1) >= DEPTH))
                  || (wr_enb_0 && (32'(wr_adr_0) >= DEPTH));

   // Capture stage; the error flag is computed from the raw inputs so it lands in C+1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_strobe   <= 1'b0;
         r_rd_enb_0 <= 1'b0;
         r_rd_enb_1 <= 1'b0;
         r_wr_enb_0 <= 1'b0;
         r_rd_adr_0 <= '0;
         r_rd_adr_1 <= '0;
         r_wr_adr_0 <= '0;
         r_wr_dat_0 <= '0;
         r_adr_err  <= 1'b0;
      end else begin
         r_strobe   <= strobe;
         r_rd_enb_0 <= rd_enb_0;
         r_rd_enb_1 <= rd_enb_1;
         r_wr_enb_0 <= wr_enb_0;
         r_rd_adr_0 <= rd_adr_0;
         r_rd_adr_1 <= rd_adr_1;
         r_wr_adr_0 <= wr_adr_0;
         r_wr_dat_0 <= wr_dat_0;
         r_adr_err  <= w_err_in;
      end
   end

   assign adr_err = r_adr_err;

   logic [NBANK-1:0] w_wr_sel, w_rd_sel_0, w_rd_sel_1;
   logic [WIDTH-1:0] w_bank_rd_0 [NBANK];
   logic [WIDTH-1:0] w_bank_rd_1 [NBANK];
   logic [WIDTH-1:0] w_arr_0, w_arr_1, w_rd_0, w_rd_1;
   logic             w_hit_0, w_hit_1;

   // Bank select; out-of-range addresses match no bank
   always_comb begin
      w_wr_sel   = '0;
      w_rd_sel_0 = '0;
      w_rd_sel_1 = '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
         w_wr_sel[b]   = r_wr_enb_0 && (bank_idx(32'(r_wr_adr_0)) == b);
         w_rd_sel_0[b] = r_rd_enb_0 && (bank_idx(32'(r_rd_adr_0)) == b);
         w_rd_sel_1[b] = r_rd_enb_1 && (bank_idx(32'(r_rd_adr_1)) == b);
      end
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      ra_bank_64_2r1w #(
         .WIDTH   (WIDTH),
         .GENMODE (GENMODE)
      ) u_bank (
         .clk      (clk),
         .strobe   (r_strobe),
         .wr_en    (w_wr_sel[b]),
         .wr_row   (ROW_W'(r_wr_adr_0)),
         .wr_dat   (r_wr_dat_0),
         .rd_en_0  (w_rd_sel_0[b]),
         .rd_row_0 (ROW_W'(r_rd_adr_0)),
         .rd_dat_0 (w_bank_rd_0[b]),
         .rd_en_1  (w_rd_sel_1[b]),
         .rd_row_1 (ROW_W'(r_rd_adr_1)),
         .rd_dat_1 (w_bank_rd_1[b])
      );
   end

   always_comb begin
      w_arr_0 = '0;
      w_arr_1 = '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
         w_arr_0 = w_arr_0 | w_bank_rd_0[b];
         w_arr_1 = w_arr_1 | w_bank_rd_1[b];
      end
   end

`ifdef RA_WR_BYPASS_EN
   assign w_hit_0 = r_rd_enb_0 && r_wr_enb_0 && r_strobe && (r_rd_adr_0 == r_wr_adr_0)
                 && (32'(r_wr_adr_0) < DEPTH);
   assign w_hit_1 = r_rd_enb_1 && r_wr_enb_0 && r_strobe && (r_rd_adr_1 == r_wr_adr_0)
                 && (32'(r_wr_adr_0) < DEPTH);
`else
   assign w_hit_0 = 1'b0;
   assign w_hit_1 = 1'b0;
`endif

   assign w_rd_0 = w_hit_0 ? r_wr_dat_0 : w_arr_0;
   assign w_rd_1 = w_hit_1 ? r_wr_dat_0 : w_arr_1;

   if (LATCHRD != 0) begin : g_latch
      logic [WIDTH-1:0] r_rd_dat_0, r_rd_dat_1;
      logic             r_rd_val_0, r_rd_val_1;

      // Data registers load only on an enabled read and otherwise hold
      always_ff @(posedge clk) begin
         if (reset) begin
            r_rd_dat_0 <= '0;
            r_rd_dat_1 <= '0;
            r_rd_val_0 <= 1'b0;
            r_rd_val_1 <= 1'b0;
         end else begin
            r_rd_val_0 <= r_rd_enb_0;
            r_rd_val_1 <= r_rd_enb_1;
            if (r_rd_enb_0) r_rd_dat_0 <= w_rd_0;
            if (r_rd_enb_1) r_rd_dat_1 <= w_rd_1;
         end
      end

      assign rd_dat_0 = r_rd_dat_0;
      assign rd_dat_1 = r_rd_dat_1;
      assign rd_val_0 = r_rd_val_0;
      assign rd_val_1 = r_rd_val_1;
   end else begin : g_comb
      assign rd_dat_0 = w_rd_0;
      assign rd_dat_1 = w_rd_1;
      assign rd_val_0 = r_rd_enb_0;
      assign rd_val_1 = r_rd_enb_1;
   end

endmodule
